// File: rtl/arp_req_gen.sv
// ARP request frame generator.
// Incoming resolve requests {req_netport, req_ip} are buffered in a small FIFO
// and each one is turned into a 60-byte ARP request frame on a byte stream
// with valid/ready handshake, followed by a fixed idle gap.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame in progress, waiting for a queued request
// LOAD   | pop queue head into frame registers, capture tx_netport
// SEND   | stream 60 frame bytes, byte index advances on acceptance
// GAP    | hold tx_valid low for GAP_CYCLES cycles (min one cycle)
//
// QDEPTH_LOG2 must be at least 1.

module arp_req_gen #(
    parameter int QDEPTH_LOG2 = 2,
    parameter int GAP_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] req_netport,
    input  logic [31:0] req_ip,
    input  logic        req_en,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    input  logic        tx_ready,
    output logic [23:0] tx_netport,
    output logic [15:0] drop_cnt
);

    localparam int QDEPTH = 1 << QDEPTH_LOG2;
    localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Gap down-counter start value; a zero gap still spends one cycle in GAP.
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [5:0]    LAST_IDX = 6'd59;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request queue storage and pointers (one extra wrap bit each).
    logic [55:0]            q_mem [QDEPTH];
    logic [QDEPTH_LOG2:0]   wr_ptr;
    logic [QDEPTH_LOG2:0]   rd_ptr;
    logic                   q_empty;
    logic                   q_full;
    logic                   q_push;
    logic                   q_pop;

    // Frame engine registers.
    logic [31:0]            tgt_ip;
    logic [5:0]             byte_idx;
    logic [GW-1:0]          gap_cnt;
    logic                   accept;
    logic                   last_accept;
    logic [479:0]           frame_vec;
    logic [8:0]             bit_base;
    logic [7:0]             cur_byte;

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[QDEPTH_LOG2] != rd_ptr[QDEPTH_LOG2]) &&
                     (wr_ptr[QDEPTH_LOG2-1:0] == rd_ptr[QDEPTH_LOG2-1:0]);

    // Fullness is judged before this edge's pop, so a same-cycle pop never
    // makes room for an incoming request.
    assign q_push = req_en && !q_full;
    assign q_pop  = (state == S_LOAD) && !q_empty;

    assign accept      = tx_valid && tx_ready;
    assign last_accept = accept && (byte_idx == LAST_IDX);

    // Queue pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (q_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Queue storage write; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_mem[wr_ptr[QDEPTH_LOG2-1:0]] <= {req_netport, req_ip};
        end
    end

    // Saturating count of requests discarded on a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (req_en && q_full && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (last_accept) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the popped request; tx_netport then holds for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_ip     <= '0;
            tx_netport <= '0;
        end else if (q_pop) begin
            tgt_ip     <= q_mem[rd_ptr[QDEPTH_LOG2-1:0]][31:0];
            tx_netport <= q_mem[rd_ptr[QDEPTH_LOG2-1:0]][55:32];
        end
    end

    // Byte index advances only on accepted bytes; gap timer counts down in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    byte_idx <= '0;
                end
                S_SEND: begin
                    if (last_accept) begin
                        byte_idx <= '0;
                        gap_cnt  <= GAP_LOAD;
                    end else if (accept) begin
                        byte_idx <= byte_idx + 6'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    byte_idx <= '0;
                end
            endcase
        end
    end

    // Whole frame laid out MSB-first; byte 0 sits in the top eight bits.
    always_comb begin
        frame_vec = {
            48'hFFFF_FFFF_FFFF,     // 0-5   broadcast destination
            local_mac,              // 6-11  source MAC
            16'h0806,               // 12-13 ethertype ARP
            16'h0001,               // 14-15 hardware type Ethernet
            16'h0800,               // 16-17 protocol type IPv4
            8'h06,                  // 18    hardware size
            8'h04,                  // 19    protocol size
            16'h0001,               // 20-21 opcode request
            local_mac,              // 22-27 sender MAC
            local_ip,               // 28-31 sender IP
            48'h0,                  // 32-37 target MAC unknown
            tgt_ip,                 // 38-41 target IP
            144'h0                  // 42-59 padding to minimum frame size
        };
    end

    // Select the current byte out of the frame image.
    always_comb begin
        bit_base = 9'd479 - {byte_idx, 3'b000};
        cur_byte = frame_vec[bit_base -: 8];
    end

    // Stream outputs derive from registered state, so reset clears them at once.
    always_comb begin
        tx_valid = (state == S_SEND);
        tx_sof   = tx_valid && (byte_idx == 6'd0);
        tx_eof   = tx_valid && (byte_idx == LAST_IDX);
        tx_data  = tx_valid ? cur_byte : 8'h00;
    end

endmodule
